// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg: shared constants for the LCD window controller.
// Command codes and FSM state encoding.
package lcd_ctrl_pkg;

  localparam logic [3:0] CMD_WRITE = 4'd0;
  localparam logic [3:0] CMD_UP    = 4'd1;
  localparam logic [3:0] CMD_DOWN  = 4'd2;
  localparam logic [3:0] CMD_LEFT  = 4'd3;
  localparam logic [3:0] CMD_RIGHT = 4'd4;
  localparam logic [3:0] CMD_MAX   = 4'd5;
  localparam logic [3:0] CMD_MIN   = 4'd6;
  localparam logic [3:0] CMD_AVG   = 4'd7;
  localparam logic [3:0] CMD_ROTL  = 4'd8;
  localparam logic [3:0] CMD_ROTR  = 4'd9;
  localparam logic [3:0] CMD_MIRX  = 4'd10;
  localparam logic [3:0] CMD_MIRY  = 4'd11;

  typedef enum logic [2:0] {
    ST_RST,
    ST_LOAD,
    ST_IDLE,
    ST_EXEC,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/lcd_win_alu.sv
// lcd_win_alu: combinational 2x2 window operator.
// In: tl/tr/bl/br pixels, cmd. Out: new pixels, we.
module lcd_win_alu
  import lcd_ctrl_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] tl,
  input  logic [DW-1:0] tr,
  input  logic [DW-1:0] bl,
  input  logic [DW-1:0] br,
  input  logic [3:0]    cmd,
  output logic [DW-1:0] tl_n,
  output logic [DW-1:0] tr_n,
  output logic [DW-1:0] bl_n,
  output logic [DW-1:0] br_n,
  output logic          we
);

  logic [DW-1:0] mx_t, mx_b, mx;
  logic [DW-1:0] mn_t, mn_b, mn;
  logic [DW+1:0] sum;
  logic [DW-1:0] avg;

  always_comb begin
    mx_t = (tl > tr) ? tl : tr;
    mx_b = (bl > br) ? bl : br;
    mx   = (mx_t > mx_b) ? mx_t : mx_b;
    mn_t = (tl < tr) ? tl : tr;
    mn_b = (bl < br) ? bl : br;
    mn   = (mn_t < mn_b) ? mn_t : mn_b;
    sum  = {2'b00, tl} + {2'b00, tr}
         + {2'b00, bl} + {2'b00, br};
    avg  = DW'(sum >> 2);
  end

  always_comb begin
    tl_n = tl;
    tr_n = tr;
    bl_n = bl;
    br_n = br;
    we   = 1'b1;
    unique case (1'b1)
      cmd == CMD_MAX: begin
        tl_n = mx; tr_n = mx;
        bl_n = mx; br_n = mx;
      end
      cmd == CMD_MIN: begin
        tl_n = mn; tr_n = mn;
        bl_n = mn; br_n = mn;
      end
      cmd == CMD_AVG: begin
        tl_n = avg; tr_n = avg;
        bl_n = avg; br_n = avg;
      end
      cmd == CMD_ROTL: begin
        tl_n = tr; tr_n = br;
        br_n = bl; bl_n = tl;
      end
      cmd == CMD_ROTR: begin
        tl_n = bl; bl_n = br;
        br_n = tr; tr_n = tl;
      end
      cmd == CMD_MIRX: begin
        tl_n = bl; bl_n = tl;
        tr_n = br; br_n = tr;
      end
      cmd == CMD_MIRY: begin
        tl_n = tr; tr_n = tl;
        bl_n = br; br_n = bl;
      end
      default: we = 1'b0;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl_grid.sv
// lcd_ctrl_grid: loads a frame from ROM, edits a 2x2 window
// by command, writes the frame back to RAM on cmd 0.
// Ports: clk, reset (async, low), cmd/cmd_valid, IROM_*,
// IRAM_*, busy (command not accepted), done (write end).
module lcd_ctrl_grid
  import lcd_ctrl_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW = 8,
  localparam int N = IMG_W * IMG_H,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic          IROM_rd,
  output logic [AW-1:0] IROM_A,
  input  logic [DW-1:0] IROM_Q,
  output logic          IRAM_valid,
  output logic [AW-1:0] IRAM_A,
  output logic [DW-1:0] IRAM_D,
  output logic          busy,
  output logic          done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);

  state_t state, state_n;

  logic [AW-1:0] addr;
  logic [AW-1:0] addr_inc;
  logic          last;
  logic [XW-1:0] px, pxm;
  logic [YW-1:0] py, pym;
  logic [3:0]    cmd_q;
  logic [DW-1:0] mem [N];

  logic [AW-1:0] i_tl, i_tr, i_bl, i_br;
  logic [DW-1:0] w_tl, w_tr, w_bl, w_br;
  logic [DW-1:0] n_tl, n_tr, n_bl, n_br;
  logic          alu_we;

  // ROM and RAM share one address counter.
  assign IROM_A   = addr;
  assign IRAM_A   = addr;
  assign addr_inc = addr + 1'b1;
  assign last     = (addr == LAST);

  assign pxm  = px - 1'b1;
  assign pym  = py - 1'b1;
  assign i_tl = {pym, pxm};
  assign i_tr = {pym, px};
  assign i_bl = {py, pxm};
  assign i_br = {py, px};
  assign w_tl = mem[i_tl];
  assign w_tr = mem[i_tr];
  assign w_bl = mem[i_bl];
  assign w_br = mem[i_br];

  lcd_win_alu #(.DW(DW)) u_alu (
    .tl   (w_tl),
    .tr   (w_tr),
    .bl   (w_bl),
    .br   (w_br),
    .cmd  (cmd_q),
    .tl_n (n_tl),
    .tr_n (n_tr),
    .bl_n (n_bl),
    .br_n (n_br),
    .we   (alu_we)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_RST;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_RST:  state_n = ST_LOAD;
      ST_LOAD: if (last) state_n = ST_IDLE;
      ST_IDLE:
        if (cmd_valid)
          state_n = (cmd == CMD_WRITE) ? ST_WRITE
                                       : ST_EXEC;
      ST_EXEC: state_n = ST_IDLE;
      ST_WRITE:
        if (IRAM_valid && last) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_RST;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr       <= '0;
      px         <= XW'(IMG_W / 2);
      py         <= YW'(IMG_H / 2);
      cmd_q      <= '0;
      IROM_rd    <= 1'b0;
      IRAM_valid <= 1'b0;
      IRAM_D     <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else begin
      unique case (state)
        ST_RST: IROM_rd <= 1'b1;
        ST_LOAD: begin
          if (last) begin
            IROM_rd <= 1'b0;
            busy    <= 1'b0;
            addr    <= '0;
          end else begin
            addr <= addr_inc;
          end
        end
        ST_IDLE: begin
          if (cmd_valid) begin
            busy  <= 1'b1;
            cmd_q <= cmd;
            // Start one below 0 so the first
            // write cycle wraps to address 0.
            if (cmd == CMD_WRITE) addr <= LAST;
          end
        end
        ST_EXEC: begin
          busy <= 1'b0;
          unique case (1'b1)
            cmd_q == CMD_UP:
              if (py != Y_ONE) py <= pym;
            cmd_q == CMD_DOWN:
              if (py != Y_MAX) py <= py + 1'b1;
            cmd_q == CMD_LEFT:
              if (px != X_ONE) px <= pxm;
            cmd_q == CMD_RIGHT:
              if (px != X_MAX) px <= px + 1'b1;
            default: ;
          endcase
        end
        ST_WRITE: begin
          // valid distinguishes the final
          // address from the initial wrap.
          if (IRAM_valid && last) begin
            IRAM_valid <= 1'b0;
            done       <= 1'b1;
            addr       <= '0;
          end else begin
            IRAM_valid <= 1'b1;
            IRAM_D     <= mem[addr_inc];
            addr       <= addr_inc;
          end
        end
        ST_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_LOAD) begin
      mem[addr] <= IROM_Q;
    end else if (state == ST_EXEC && alu_we) begin
      mem[i_tl] <= n_tl;
      mem[i_tr] <= n_tr;
      mem[i_bl] <= n_bl;
      mem[i_br] <= n_br;
    end
  end

endmodule

// File: tb/tb_lcd_ctrl_grid.sv
// tb_lcd_ctrl_grid: directed bench for lcd_ctrl_grid,
// default 8x8x8 instance and a 16x4x10 instance.
module tb_lcd_ctrl_grid;

  logic clk;
  logic reset;
  bit   sel;
  logic [3:0] cmd_m;
  logic cv_m;

  logic [3:0] cmd1, cmd2;
  logic cv1, cv2;
  logic irom_rd1, irom_rd2;
  logic [5:0] irom_a1, irom_a2;
  logic [7:0] irom_q1;
  logic [9:0] irom_q2;
  logic iram_v1, iram_v2;
  logic [5:0] iram_a1, iram_a2;
  logic [7:0] iram_d1;
  logic [9:0] iram_d2;
  logic busy1, busy2, done1, done2;
  logic busy_m, done_m, iram_v_m;

  logic [7:0] rom1 [64];
  logic [7:0] ram1 [64];
  logic [9:0] rom2 [64];
  logic [9:0] ram2 [64];
  logic [9:0] exp_f [64];

  int n_vec = 0;
  int n_bad = 0;

  assign cmd1 = cmd_m;
  assign cmd2 = cmd_m;
  assign cv1 = cv_m & ~sel;
  assign cv2 = cv_m & sel;
  assign busy_m = sel ? busy2 : busy1;
  assign done_m = sel ? done2 : done1;
  assign iram_v_m = sel ? iram_v2 : iram_v1;

  lcd_ctrl_grid u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd1),
    .cmd_valid  (cv1),
    .IROM_rd    (irom_rd1),
    .IROM_A     (irom_a1),
    .IROM_Q     (irom_q1),
    .IRAM_valid (iram_v1),
    .IRAM_A     (iram_a1),
    .IRAM_D     (iram_d1),
    .busy       (busy1),
    .done       (done1)
  );

  lcd_ctrl_grid #(
    .IMG_W (16),
    .IMG_H (4),
    .DW    (10)
  ) u_dut2 (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd2),
    .cmd_valid  (cv2),
    .IROM_rd    (irom_rd2),
    .IROM_A     (irom_a2),
    .IROM_Q     (irom_q2),
    .IRAM_valid (iram_v2),
    .IRAM_A     (iram_a2),
    .IRAM_D     (iram_d2),
    .busy       (busy2),
    .done       (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (irom_rd1) irom_q1 <= rom1[irom_a1];
    if (irom_rd2) irom_q2 <= rom2[irom_a2];
    if (iram_v1) ram1[iram_a1] <= iram_d1;
    if (iram_v2) ram2[iram_a2] <= iram_d2;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d",
               tag, got, want);
    end
  endtask

  task automatic reset_load();
    reset = 1'b0;
    #1;
    chk("rst_busy", busy1, 1);
    chk("rst_done", done1, 0);
    chk("rst_rom_rd", irom_rd1, 0);
    chk("rst_rom_a", irom_a1, 0);
    chk("rst_ram_v", iram_v1, 0);
    chk("rst_ram_a", iram_a1, 0);
    chk("rst_ram_d", iram_d1, 0);
    chk("rst_busy2", busy2, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= 65; e++) begin
      @(posedge clk);
      #1;
      chk("ld_rom_rd", irom_rd1, e <= 64);
      if (e <= 64) chk("ld_rom_a", irom_a1, e - 1);
      chk("ld_busy", busy1, e <= 64);
    end
    chk("ld_busy2", busy2, 0);
  endtask

  task automatic ex(input logic [3:0] c,
                    input bit hold);
    @(negedge clk);
    cmd_m = c;
    cv_m = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) cv_m = 1'b0;
    chk("ex_busy", busy_m, 1);
    @(posedge clk);
    #1;
    cv_m = 1'b0;
    chk("ex_free", busy_m, 0);
  endtask

  task automatic wr(input bit hold);
    int ne;
    int nw;
    @(negedge clk);
    cmd_m = 4'd0;
    cv_m = 1'b1;
    @(posedge clk);
    #1;
    if (hold) cmd_m = 4'd4;
    else cv_m = 1'b0;
    chk("wr_busy", busy_m, 1);
    ne = 0;
    nw = 0;
    while (!done_m && ne < 80) begin
      @(posedge clk);
      #1;
      ne++;
      if (iram_v_m) nw++;
    end
    cv_m = 1'b0;
    chk("done_lat", ne, 65);
    chk("wr_cnt", nw, 64);
    chk("done_busy", busy_m, 1);
    @(posedge clk);
    #1;
    chk("done_pulse", done_m, 0);
    chk("wr_free", busy_m, 0);
  endtask

  task automatic exp_base();
    for (int k = 0; k < 64; k++) exp_f[k] = 10'(k);
  endtask

  task automatic exp_win(input int a, input int b,
                         input int c, input int d);
    exp_base();
    exp_f[27] = 10'(a);
    exp_f[28] = 10'(b);
    exp_f[35] = 10'(c);
    exp_f[36] = 10'(d);
  endtask

  task automatic frame_chk(input string tag);
    for (int k = 0; k < 64; k++)
      chk($sformatf("%s_px%0d", tag, k),
          sel ? 32'(ram2[k]) : 32'(ram1[k]),
          32'(exp_f[k]));
  endtask

  task automatic rom_win(input int a, input int b,
                         input int c, input int d);
    for (int k = 0; k < 64; k++) rom1[k] = 8'(k);
    rom1[27] = 8'(a);
    rom1[28] = 8'(b);
    rom1[35] = 8'(c);
    rom1[36] = 8'(d);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int ne;
    int nw;
    sel = 1'b0;
    cv_m = 1'b0;
    cmd_m = 4'd0;
    reset = 1'b1;
    for (int k = 0; k < 64; k++) begin
      rom1[k] = 8'(k);
      rom2[k] = 10'(k);
    end
    rom2[23] = 10'd1023;
    rom2[24] = 10'd1023;
    rom2[39] = 10'd1023;
    rom2[40] = 10'd1023;
    #1;
    reset_load();

    // identity write-back
    wr(0);
    exp_base();
    frame_chk("ident");

    // boundary shifts in every direction
    repeat (4) ex(4'd3, 0);
    ex(4'd5, 0);
    repeat (4) ex(4'd1, 0);
    ex(4'd6, 0);
    repeat (8) ex(4'd4, 0);
    repeat (8) ex(4'd2, 0);
    ex(4'd5, 0);
    wr(0);
    exp_base();
    exp_f[24] = 10'd33;
    exp_f[25] = 10'd33;
    exp_f[32] = 10'd33;
    exp_f[33] = 10'd33;
    exp_f[1] = 10'd0;
    exp_f[8] = 10'd0;
    exp_f[9] = 10'd0;
    exp_f[54] = 10'd63;
    exp_f[55] = 10'd63;
    exp_f[62] = 10'd63;
    frame_chk("bound");

    // window arithmetic
    rom_win(10, 20, 30, 41);
    reset_load();
    ex(4'd7, 0);
    wr(0);
    exp_win(25, 25, 25, 25);
    frame_chk("avg");
    reset_load();
    ex(4'd5, 0);
    wr(0);
    exp_win(41, 41, 41, 41);
    frame_chk("max");
    reset_load();
    ex(4'd6, 0);
    wr(0);
    exp_win(10, 10, 10, 10);
    frame_chk("min");

    // rotate, mirror, reserved
    rom_win(1, 2, 3, 4);
    reset_load();
    ex(4'd9, 0);
    wr(0);
    exp_win(3, 1, 4, 2);
    frame_chk("rotr");
    ex(4'd8, 0);
    wr(0);
    exp_win(1, 2, 3, 4);
    frame_chk("rotl");
    ex(4'd10, 0);
    wr(0);
    exp_win(3, 4, 1, 2);
    frame_chk("mirx");
    ex(4'd13, 0);
    wr(0);
    frame_chk("rsvd");
    ex(4'd11, 0);
    wr(0);
    exp_win(4, 3, 2, 1);
    frame_chk("miry");

    // reset in the middle of a write-back
    rom_win(27, 28, 35, 36);
    reset_load();
    ex(4'd3, 0);
    @(negedge clk);
    cmd_m = 4'd0;
    cv_m = 1'b1;
    @(posedge clk);
    #1;
    cv_m = 1'b0;
    ne = 0;
    nw = 0;
    while (nw < 20 && ne < 80) begin
      @(posedge clk);
      #1;
      ne++;
      if (iram_v1) nw++;
    end
    chk("wr20", nw, 20);
    reset_load();
    ex(4'd5, 0);
    wr(0);
    exp_win(36, 36, 36, 36);
    frame_chk("rstwr");

    // 16x4x10 instance
    sel = 1'b1;
    ex(4'd7, 0);
    ex(4'd4, 1);
    ex(4'd6, 0);
    wr(1);
    exp_base();
    exp_f[23] = 10'd1023;
    exp_f[39] = 10'd1023;
    exp_f[24] = 10'd25;
    exp_f[25] = 10'd25;
    exp_f[40] = 10'd25;
    exp_f[41] = 10'd25;
    frame_chk("g16");
    ex(4'd5, 0);
    wr(0);
    frame_chk("g16b");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
